// File: rtl/mem_arbiter_pkg.sv
// Shared defaults and state encoding for the two-master memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 64;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last-granted pointer.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  // last_q = 1 means master 1 was granted last, so master 0 wins the next tie
  logic last_q;
  logic last_d;
  logic gnt0_s;
  logic gnt1_s;

  always_comb begin
    gnt0_s = en_i & req0_i & (~req1_i | last_q);
    gnt1_s = en_i & req1_i & (~req0_i | ~last_q);
    if (gnt0_s) begin
      last_d = 1'b0;
    end else if (gnt1_s) begin
      last_d = 1'b1;
    end else begin
      last_d = last_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  assign gnt0_o = gnt0_s;
  assign gnt1_o = gnt1_s;

endmodule

// File: rtl/mem_arbiter.sv
// Clears the shared memory after reset, then arbitrates two masters onto it
// with a one-cycle read return tagged to the requesting master.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              init_done
);

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               init_done_q, init_done_d;
  logic               m0_rvalid_q, m0_rvalid_d;
  logic               m1_rvalid_q, m1_rvalid_d;
  logic               gnt0_s, gnt1_s;
  logic               mem_rd_en_s, mem_wr_en_s;
  logic [ADDR_W-1:0]  mem_rd_addr_s, mem_wr_addr_s;
  logic [DATA_W-1:0]  mem_wr_data_s;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q == ST_ARB),
    .req0_i (m0_req),
    .req1_i (m1_req),
    .gnt0_o (gnt0_s),
    .gnt1_o (gnt1_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          state_d = ST_ARB;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_ARB:  state_d = ST_ARB;
      default: state_d = ST_INIT;
    endcase
    init_done_d = (state_d == ST_ARB);
    m0_rvalid_d = gnt0_s & ~m0_we;
    m1_rvalid_d = gnt1_s & ~m1_we;
  end

  // Enables are gated by rst_n so the clear sweep is silent while reset is held
  always_comb begin
    mem_rd_en_s   = 1'b0;
    mem_wr_en_s   = 1'b0;
    mem_rd_addr_s = '0;
    mem_wr_addr_s = '0;
    mem_wr_data_s = '0;
    if (state_q == ST_INIT) begin
      mem_wr_en_s   = rst_n;
      mem_wr_addr_s = ADDR_W'(cnt_q);
    end else if (gnt0_s) begin
      if (m0_we) begin
        mem_wr_en_s   = 1'b1;
        mem_wr_addr_s = m0_addr;
        mem_wr_data_s = m0_wdata;
      end else begin
        mem_rd_en_s   = 1'b1;
        mem_rd_addr_s = m0_addr;
      end
    end else if (gnt1_s) begin
      if (m1_we) begin
        mem_wr_en_s   = 1'b1;
        mem_wr_addr_s = m1_addr;
        mem_wr_data_s = m1_wdata;
      end else begin
        mem_rd_en_s   = 1'b1;
        mem_rd_addr_s = m1_addr;
      end
    end else begin
      mem_rd_en_s = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
    end
  end

  assign m0_gnt      = gnt0_s;
  assign m1_gnt      = gnt1_s;
  assign m0_rvalid   = m0_rvalid_q;
  assign m1_rvalid   = m1_rvalid_q;
  assign m0_rdata    = mem_rd_data;
  assign m1_rdata    = mem_rd_data;
  assign mem_rd_en   = mem_rd_en_s;
  assign mem_wr_en   = mem_wr_en_s;
  assign mem_rd_addr = mem_rd_addr_s;
  assign mem_wr_addr = mem_wr_addr_s;
  assign mem_wr_data = mem_wr_data_s;
  assign init_done   = init_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter with a behavioural 64x8 memory.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [5:0] m0_addr = 6'd0, m1_addr = 6'd0;
  logic [7:0] m0_wdata = 8'd0, m1_wdata = 8'd0;
  logic       m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [7:0] m0_rdata, m1_rdata;
  logic       mem_rd_en, mem_wr_en;
  logic [5:0] mem_rd_addr, mem_wr_addr;
  logic [7:0] mem_wr_data;
  logic [7:0] mem_rd_data = 8'd0;
  logic       init_done;

  logic [7:0] mem [64];
  logic       fill = 1'b1;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    bit         m;
    logic [7:0] d;
    int         c;
  } exp_t;
  exp_t exp_q[$];

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .init_done(init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory starts as 0xFF everywhere so the clear sweep is observable
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'hFF;
    end else begin
      if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every rvalid must match the oldest expected read
  always @(negedge clk) begin
    if (m0_rvalid || m1_rvalid) begin
      check("single_rvalid", {31'd0, m0_rvalid & m1_rvalid}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rvalid_owner", {30'd0, m1_rvalid, m0_rvalid}, e.m ? 32'd2 : 32'd1);
        check("rdata", {24'd0, (e.m ? m1_rdata : m0_rdata)}, {24'd0, e.d});
        check("rvalid_cycle", cyc, e.c);
      end
    end
  end

  task automatic step(input bit r0, input bit w0, input logic [5:0] a0, input logic [7:0] d0,
                      input bit r1, input bit w1, input logic [5:0] a1, input logic [7:0] d1,
                      input bit eg0, input bit eg1, input logic [7:0] erd);
    exp_t e;
    @(negedge clk);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    #1;
    check("m0_gnt", {31'd0, m0_gnt}, {31'd0, eg0});
    check("m1_gnt", {31'd0, m1_gnt}, {31'd0, eg1});
    check("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, (eg0 && w0) || (eg1 && w1)});
    check("mem_rd_en", {31'd0, mem_rd_en}, {31'd0, (eg0 && !w0) || (eg1 && !w1)});
    if (eg0 || eg1) begin
      if ((eg0 && w0) || (eg1 && w1)) begin
        check("mem_wr_addr", {26'd0, mem_wr_addr}, {26'd0, eg0 ? a0 : a1});
        check("mem_wr_data", {24'd0, mem_wr_data}, {24'd0, eg0 ? d0 : d1});
      end else begin
        check("mem_rd_addr", {26'd0, mem_rd_addr}, {26'd0, eg0 ? a0 : a1});
        e.m = eg1; e.d = erd; e.c = cyc + 1;
        exp_q.push_back(e);
      end
    end else begin
      check("idle_bus", {10'd0, mem_rd_addr, mem_wr_addr, mem_wr_data}, 32'd0);
    end
  endtask

  // Releases reset with both masters requesting and checks the full clear sweep
  task automatic run_init();
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 6'd0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'd0;
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      #1;
      check("init_wr_en", {31'd0, mem_wr_en}, 32'd1);
      check("init_wr_addr", {26'd0, mem_wr_addr}, i);
      check("init_wr_data", {24'd0, mem_wr_data}, 32'd0);
      check("init_no_gnt", {29'd0, m0_gnt, m1_gnt, mem_rd_en}, 32'd0);
      check("init_done_low", {31'd0, init_done}, 32'd0);
      @(negedge clk);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    #1;
    check("init_done_high", {31'd0, init_done}, 32'd1);
    check("post_init_wr_en", {31'd0, mem_wr_en}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    fill = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    #1;
    check("rst_outputs", {26'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_wr_en, mem_rd_en}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    run_init();

    // m0 writes addr 5, m1 reads it back the next cycle
    step(1'b1, 1'b1, 6'd5, 8'hA5, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 6'd5, 8'h00, 1'b0, 1'b1, 8'hA5);
    // continuous reads from both masters alternate starting with m0
    step(1'b1, 1'b0, 6'd5, 8'h00, 1'b1, 1'b0, 6'd7, 8'h00, 1'b1, 1'b0, 8'hA5);
    step(1'b1, 1'b0, 6'd5, 8'h00, 1'b1, 1'b0, 6'd7, 8'h00, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 6'd5, 8'h00, 1'b1, 1'b0, 6'd7, 8'h00, 1'b1, 1'b0, 8'hA5);
    step(1'b1, 1'b0, 6'd5, 8'h00, 1'b1, 1'b0, 6'd7, 8'h00, 1'b0, 1'b1, 8'h00);
    // m1 alone, then a tie goes to m0; m1 waits and reads the freshly written addr 63
    step(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 6'd5, 8'h00, 1'b0, 1'b1, 8'hA5);
    step(1'b1, 1'b1, 6'd63, 8'h3C, 1'b1, 1'b0, 6'd63, 8'h00, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 6'd63, 8'h00, 1'b0, 1'b1, 8'h3C);
    step(1'b1, 1'b0, 6'd10, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 8'h00);
    check("queue_drained", exp_q.size(), 32'd0);

    // Reset lands while a read of addr 63 is in flight
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 6'd63;
    #1;
    check("pre_rst_gnt", {31'd0, m0_gnt}, 32'd1);
    @(posedge clk);
    #1;
    check("pre_rst_rvalid", {31'd0, m0_rvalid}, 32'd1);
    #1;
    rst_n = 1'b0;
    m0_req = 1'b0;
    #1;
    check("rst_rvalid_cleared", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
    check("rst_quiet", {28'd0, m0_gnt, m1_gnt, mem_wr_en, mem_rd_en}, 32'd0);
    check("rst_init_done_low", {31'd0, init_done}, 32'd0);
    repeat (3) @(negedge clk);
    run_init();

    step(1'b1, 1'b0, 6'd63, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 6'd5, 8'h00, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 8'h00);
    check("final_queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
